delay_profile_scheduler: RTL
============================

Name: delay_profile_scheduler

Overview:
Sequences the delay_type configuration of up to NUM_ELEMENTS rise/fall delay elements in the 802.3da simulation harness. It sweeps minimum, typical and maximum delays, holds a fixed profile, or re-randomises delays periodically. Every profile change is gated by a quiesce handshake so delays never change while a transfer is in flight. It also generates the new_values event that random-mode delay elements use to re-draw their values.

Parameters:
NUM_ELEMENTS, 4, number of delay elements driven.
DWELL_WIDTH, 16, width of the dwell counter (counts frame_done pulses).
DEFAULT_TYPE, 3'd0, delay_type driven out of reset.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  start/continue scheduling; low aborts to IDLE.
mode  input  2  0 = fixed, 1 = sweep, 2 = random; 3 is treated as fixed. Latched on start.
cfg_type  input  3  delay type for fixed mode. Latched on start.
dwell  input  DWELL_WIDTH  frame_done pulses per step. Latched on start; 0 is treated as 1.
elem_mask  input  NUM_ELEMENTS  1 = element is updated on apply. Sampled in APPLY.
frame_done  input  1  one-cycle pulse at each frame/transfer boundary.
quiesce_ack  input  1  link idle; it is safe to change delays.
quiesce_req  output  1  request for the link to go idle before an apply.
delay_type  output  3*NUM_ELEMENTS  element k uses bits [3k+2:3k].
new_values  output  1  one-cycle pulse after every apply.
busy  output  1  high in REQ, APPLY or DWELL.
sweep_done  output  1  sweep finished; held until leaving DONE.
step_count  output  8  number of applies since start; saturates at 255.

Behaviour:
- Encodings: no_delay = 0, minimum = 1, typical = 2, maximum = 3, random = 4. cfg_type values 5–7 are applied as 0.
- Reset (synchronous):
  - state = IDLE.
  - Every delay_type field = DEFAULT_TYPE.
  - quiesce_req, new_values, busy, sweep_done = 0; step_count = 0.
  - Dwell counter and sweep index = 0.
  - Reset overrides every other input in the same cycle.
- States: IDLE, REQ, APPLY, DWELL, HOLD, DONE. The state register is updated on the clock.
- IDLE, enable = 1: latch mode, cfg_type and dwell; clear step_count and sweep index; go to REQ.
- REQ:
  - quiesce_req = 1.
  - quiesce_ack = 1 sampled goes to APPLY. If ack is already high, APPLY follows on the next cycle.
  - enable = 0 goes to IDLE with no apply.
  - frame_done is ignored.
- APPLY (exactly one cycle):
  - quiesce_req stays 1.
  - Each masked element's delay_type is loaded with next_type; unmasked elements hold their value.
  - new_values is registered high for the following cycle only, coincident with the new delay_type becoming visible.
  - step_count increments, saturating at 255.
  - Dwell counter clears.
  - enable is not checked in this cycle; the apply always completes.
- next_type by mode:
  - Fixed: cfg_type.
  - Sweep: 1, 2, 3 for sweep index 0, 1, 2.
  - Random: 4.
- Exit from APPLY:
  - Fixed goes to HOLD.
  - Sweep goes to DONE after index 2, otherwise increments the index and goes to DWELL.
  - Random goes to DWELL.
- quiesce_req = 1 only in REQ and APPLY.
- DWELL:
  - Each frame_done increments the dwell counter.
  - A frame_done that brings the count to the effective dwell value goes to REQ.
  - enable = 0 goes to IDLE; delay_type holds.
- HOLD: stay until enable = 0, then go to IDLE.
- DONE: sweep_done = 1; enable = 0 goes to IDLE and clears sweep_done on the same edge.
- delay_type is never changed except in APPLY or reset. Aborting via enable preserves the last applied profile.
- Random mode runs indefinitely: REQ, APPLY, then dwell, repeated.

Test Plan:
- Reset check: reset = 1 for 2 cycles with DEFAULT_TYPE = 0 -> delay_type = 12'h000, all outputs 0, state IDLE.
- Fixed apply:
  - Stimulus: mode = 0, cfg_type = 3, elem_mask = 4'b0101, quiesce_ack tied high, enable rises.
  - Required: quiesce_req high 2 cycles; delay_type = 12'h0C3 (elements 0 and 2 = 3, elements 1 and 3 = 0); new_values high 1 cycle; step_count = 1; state HOLD.
- Sweep:
  - Stimulus: mode = 1, dwell = 3, mask = 4'hF, ack high, frame_done every 10 cycles.
  - Required: fields step 1, then 2, then 3, each change following the 3rd frame_done; step_count = 3; sweep_done = 1; exactly 3 new_values pulses.
- Handshake stall: quiesce_ack held low 50 cycles in REQ -> quiesce_req stays high, delay_type unchanged, no new_values; ack high -> apply on the next cycle.
- Abort: enable drops in REQ in sweep step 2 -> IDLE next cycle, delay_type stays at all-1s (12'h249), quiesce_req = 0, no new_values.
- Random with dwell = 0: mode = 2, dwell = 0 -> fields = 4; new_values pulses after every frame_done; step_count saturates at 255 after 300 frames.

Source files
------------

// File: rtl/delay_profile_scheduler_if.sv
// Control and status bundle between the delay-profile scheduler and the harness.
// The harness side (master) drives the controls; the scheduler side (slave) drives the profile.
interface delay_profile_scheduler_if #(
  parameter int NUM_ELEMENTS = 4,
  parameter int DWELL_WIDTH  = 16
);
  logic                      enable;
  logic [1:0]                mode;
  logic [2:0]                cfg_type;
  logic [DWELL_WIDTH-1:0]    dwell;
  logic [NUM_ELEMENTS-1:0]   elem_mask;
  logic                      frame_done;
  logic                      quiesce_ack;
  logic                      quiesce_req;
  logic [3*NUM_ELEMENTS-1:0] delay_type;
  logic                      new_values;
  logic                      busy;
  logic                      sweep_done;
  logic [7:0]                step_count;

  modport master (
    output enable, mode, cfg_type, dwell, elem_mask, frame_done, quiesce_ack,
    input  quiesce_req, delay_type, new_values, busy, sweep_done, step_count
  );

  modport slave (
    input  enable, mode, cfg_type, dwell, elem_mask, frame_done, quiesce_ack,
    output quiesce_req, delay_type, new_values, busy, sweep_done, step_count
  );
endinterface

// File: rtl/delay_profile_scheduler.sv
// Sequences delay_type profiles (fixed, min/typ/max sweep, periodic random) for the
// harness delay elements, gating every change behind a quiesce handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for enable; last applied profile is held
// S_REQ   | quiesce_req raised, waiting for quiesce_ack
// S_APPLY | one cycle: masked elements load next_type
// S_DWELL | counting frame_done pulses before the next request
// S_HOLD  | fixed profile applied; waiting for enable to drop
// S_DONE  | sweep finished; sweep_done held until enable drops
module delay_profile_scheduler #(
  parameter int         NUM_ELEMENTS = 4,
  parameter int         DWELL_WIDTH  = 16,
  parameter logic [2:0] DEFAULT_TYPE = 3'd0
) (
  input logic                    clk,
  input logic                    reset,
  delay_profile_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_APPLY, S_DWELL, S_HOLD, S_DONE
  } state_t;

  localparam logic [1:0] MODE_SWEEP  = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  logic [1:0]                mode_q;
  logic [2:0]                cfg_q;
  logic [DWELL_WIDTH-1:0]    dwell_q;
  logic [DWELL_WIDTH-1:0]    dwell_cnt;
  logic [1:0]                sweep_idx;
  logic [3*NUM_ELEMENTS-1:0] delay_q;
  logic                      qreq_q;
  logic                      nv_q;
  logic                      busy_q;
  logic                      done_q;
  logic [7:0]                step_q;

  logic [2:0]                next_type;
  logic [DWELL_WIDTH-1:0]    dwell_eff;
  logic                      dwell_hit;

  always_comb begin
    next_type = 3'd0;
    case (mode_q)
      MODE_SWEEP:  next_type = {1'b0, sweep_idx} + 3'd1;
      MODE_RANDOM: next_type = 3'd4;
      default:     next_type = (cfg_q > 3'd4) ? 3'd0 : cfg_q;
    endcase
  end

  // A dwell of zero would never terminate, so it behaves as one frame.
  assign dwell_eff = (dwell_q == '0) ? DWELL_ONE : dwell_q;
  assign dwell_hit = (dwell_cnt + DWELL_ONE) >= dwell_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= 2'd0;
      cfg_q     <= 3'd0;
      dwell_q   <= '0;
      dwell_cnt <= '0;
      sweep_idx <= 2'd0;
      delay_q   <= {NUM_ELEMENTS{DEFAULT_TYPE}};
      qreq_q    <= 1'b0;
      nv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= 8'd0;
    end else begin
      nv_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            mode_q    <= bus.mode;
            cfg_q     <= bus.cfg_type;
            dwell_q   <= bus.dwell;
            step_q    <= 8'd0;
            sweep_idx <= 2'd0;
            state     <= S_REQ;
            qreq_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_REQ: begin
          if (!bus.enable) begin
            state  <= S_IDLE;
            qreq_q <= 1'b0;
            busy_q <= 1'b0;
          end else if (bus.quiesce_ack) begin
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          for (int k = 0; k < NUM_ELEMENTS; k++) begin
            if (bus.elem_mask[k]) delay_q[3*k +: 3] <= next_type;
          end
          nv_q      <= 1'b1;
          qreq_q    <= 1'b0;
          dwell_cnt <= '0;
          if (step_q != 8'hFF) step_q <= step_q + 8'd1;
          if (mode_q == MODE_SWEEP) begin
            if (sweep_idx == 2'd2) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              sweep_idx <= sweep_idx + 2'd1;
              state     <= S_DWELL;
            end
          end else if (mode_q == MODE_RANDOM) begin
            state <= S_DWELL;
          end else begin
            state  <= S_HOLD;
            busy_q <= 1'b0;
          end
        end
        S_DWELL: begin
          if (!bus.enable) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (bus.frame_done) begin
            if (dwell_hit) begin
              state  <= S_REQ;
              qreq_q <= 1'b1;
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_ONE;
            end
          end
        end
        S_HOLD: begin
          if (!bus.enable) state <= S_IDLE;
        end
        S_DONE: begin
          if (!bus.enable) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.quiesce_req = qreq_q;
  assign bus.delay_type  = delay_q;
  assign bus.new_values  = nv_q;
  assign bus.busy        = busy_q;
  assign bus.sweep_done  = done_q;
  assign bus.step_count  = step_q;

endmodule
